// File: rtl/ex_stage_if.sv
// Operand/result bundle and valid/ready handshake between the issue side and ex_stage.
interface ex_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [4:0]  writereg;
    logic        regwrite;
    logic        branch;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluresult;
    logic        zero;
    logic [4:0]  out_writereg;
    logic        out_regwrite;
    logic        branch_taken;
    logic        overflow;

    modport master (
        output in_valid, alucontrol, srca, srcb, writereg, regwrite, branch, flush, out_ready,
        input  in_ready, out_valid, aluresult, zero, out_writereg, out_regwrite, branch_taken, overflow
    );

    modport slave (
        input  in_valid, alucontrol, srca, srcb, writereg, regwrite, branch, flush, out_ready,
        output in_ready, out_valid, aluresult, zero, out_writereg, out_regwrite, branch_taken, overflow
    );
endinterface

// File: rtl/ex_stage.sv
// Registered single-cycle ALU execute stage with valid/ready handshake and flush.
// Define EX_OVERFLOW_TRAP_EN to build signed-overflow detection on ADD/SUB.
module ex_stage (
    input logic       clk,
    input logic       rst_n,
    ex_stage_if.slave bus
);
    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_ZERO = 3'b011,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

    alu_op_e     op;
    logic [31:0] sum;
    logic [32:0] dif33;
    logic [31:0] res;
    logic        ovf;
    logic        accept;

    logic        valid_q, valid_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic [4:0]  wreg_q, wreg_d;
    logic        rw_q, rw_d;
    logic        bt_q, bt_d;
    logic        ovf_q, ovf_d;

    assign op  = alu_op_e'(bus.alucontrol);
    assign sum = bus.srca + bus.srcb;
    // Sign-extended subtraction cannot overflow, so bit 32 is the true sign for SLT.
    assign dif33 = {bus.srca[31], bus.srca} - {bus.srcb[31], bus.srcb};

    always_comb begin
        res = '0;
        case (op)
            ALU_AND:  res = bus.srca & bus.srcb;
            ALU_OR:   res = bus.srca | bus.srcb;
            ALU_ADD:  res = sum;
            ALU_ZERO: res = '0;
            ALU_ANDN: res = bus.srca & ~bus.srcb;
            ALU_ORN:  res = bus.srca | ~bus.srcb;
            ALU_SUB:  res = dif33[31:0];
            ALU_SLT:  res = {31'd0, dif33[32]};
            default:  res = '0;
        endcase
    end

`ifdef EX_OVERFLOW_TRAP_EN
    logic add_ovf;
    logic sub_ovf;
    assign add_ovf = (bus.srca[31] == bus.srcb[31]) && (sum[31] != bus.srca[31]);
    assign sub_ovf = (bus.srca[31] != bus.srcb[31]) && (dif33[31] != bus.srca[31]);
    assign ovf     = ((op == ALU_ADD) && add_ovf) || ((op == ALU_SUB) && sub_ovf);
`else
    assign ovf = 1'b0;
`endif

    assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        wreg_d   = wreg_q;
        rw_d     = rw_q;
        bt_d     = bt_q;
        ovf_d    = ovf_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            result_d = res;
            zero_d   = (res == '0);
            wreg_d   = bus.writereg;
            rw_d     = bus.regwrite && !ovf;
            bt_d     = bus.branch && (res == '0);
            ovf_d    = ovf;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            wreg_q   <= '0;
            rw_q     <= 1'b0;
            bt_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            wreg_q   <= wreg_d;
            rw_q     <= rw_d;
            bt_q     <= bt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.aluresult    = result_q;
    assign bus.zero         = zero_q;
    assign bus.out_writereg = wreg_q;
    assign bus.out_regwrite = valid_q && rw_q;
    assign bus.branch_taken = valid_q && bt_q;
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against a signed-arithmetic reference model.
module tb_ex_stage;
    logic clk;
    logic rst_n;
    ex_stage_if bus ();

    ex_stage dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

`ifdef EX_OVERFLOW_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    int total = 0;
    int bad   = 0;

    bit          m_valid;
    logic [31:0] m_res;
    bit          m_zero;
    logic [4:0]  m_wreg;
    bit          m_rw;
    bit          m_bt;
    bit          m_ov;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output bit ov);
        longint sa;
        longint sb;
        longint wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ov = 1'b0;
        wide = 0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin wide = sa + sb; r = wide[31:0]; ov = (wide > MAXS) || (wide < MINS); end
            3'd3: r = 32'd0;
            3'd4: r = a & ~b;
            3'd5: r = a | ~b;
            3'd6: begin wide = sa - sb; r = wide[31:0]; ov = (wide > MAXS) || (wide < MINS); end
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        if (!TRAP) ov = 1'b0;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_res = '0; m_zero = 0; m_wreg = '0; m_rw = 0; m_bt = 0; m_ov = 0;
    endtask

    task automatic check_outputs();
        check("out_valid",    32'(bus.out_valid),    32'(m_valid));
        check("aluresult",    bus.aluresult,         m_res);
        check("zero",         32'(bus.zero),         32'(m_zero));
        check("out_writereg", 32'(bus.out_writereg), 32'(m_wreg));
        check("out_regwrite", 32'(bus.out_regwrite), 32'(m_valid && m_rw));
        check("branch_taken", 32'(bus.branch_taken), 32'(m_valid && m_bt));
        check("overflow",     32'(bus.overflow),     32'(m_ov));
    endtask

    // Called at a falling edge: apply inputs, predict the next rising edge, check at the following fall.
    task automatic step(input bit iv, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wr, input bit rw, input bit br, input bit fl, input bit ordy);
        bit          rdy;
        logic [31:0] r;
        bit          ov;
        bus.in_valid = iv; bus.alucontrol = op; bus.srca = a; bus.srcb = b;
        bus.writereg = wr; bus.regwrite = rw; bus.branch = br; bus.flush = fl; bus.out_ready = ordy;
        #1;
        rdy = !fl && (!m_valid || ordy);
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        if (fl) begin
            m_valid = 0;
        end else if (iv && rdy) begin
            alu_ref(op, a, b, r, ov);
            m_valid = 1; m_res = r; m_zero = (r == 0); m_wreg = wr;
            m_rw = rw && !ov; m_bt = br && (r == 0); m_ov = ov;
        end else if (ordy) begin
            m_valid = 0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 0; bus.alucontrol = '0; bus.srca = '0; bus.srcb = '0;
        bus.writereg = '0; bus.regwrite = 0; bus.branch = 0; bus.flush = 0; bus.out_ready = 1;
        model_reset();
        #3;
        check_outputs();
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        #4 rst_n = 1'b1;
        @(negedge clk);

        // Signed overflow on ADD
        step(1, 3'b010, 32'h7FFF_FFFF, 32'd1, 5'd3, 1, 0, 0, 1);
        check("add_res", bus.aluresult, 32'h8000_0000);
        check("add_zero", 32'(bus.zero), 32'd0);
        check("add_ovf", 32'(bus.overflow), 32'(TRAP));
        check("add_rw", 32'(bus.out_regwrite), 32'(!TRAP));

        step(1, 3'b111, 32'hFFFF_FFFF, 32'd1, 5'd4, 1, 0, 0, 1);
        check("slt_neg", bus.aluresult, 32'd1);
        step(1, 3'b111, 32'd1, 32'hFFFF_FFFF, 5'd4, 1, 0, 0, 1);
        check("slt_swap", bus.aluresult, 32'd0);

        step(1, 3'b110, 32'h1234, 32'h1234, 5'd0, 0, 1, 0, 1);
        check("beq_res", bus.aluresult, 32'd0);
        check("beq_zero", 32'(bus.zero), 32'd1);
        check("beq_taken", 32'(bus.branch_taken), 32'd1);

        // Backpressure: held result must not move while out_ready is low
        step(1, 3'b000, 32'hAAAA_AAAA, 32'hF0F0_F0F0, 5'd7, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 3'b010, 32'd1, 32'd2, 5'd9, 1, 0, 0, 0);
            check("bp_hold", bus.aluresult, 32'hA0A0_A0A0);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        step(1, 3'b001, 32'h0000_00F0, 32'h0000_000F, 5'd9, 1, 0, 0, 1);
        check("bp_release", bus.aluresult, 32'h0000_00FF);

        step(1, 3'b010, 32'd5, 32'd6, 5'd2, 1, 0, 1, 0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_nocap", bus.aluresult, 32'h0000_00FF);

        // Asynchronous reset in mid-cycle while a result is held
        step(1, 3'b001, 32'h55, 32'h0, 5'd12, 1, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        bus.in_valid = 0; bus.out_ready = 1; bus.flush = 0;
        #1 rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check_outputs();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = pick_operand();
            b = ($urandom_range(0, 5) == 0) ? a : pick_operand();
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b, 5'($urandom),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1, upstream operation valid.
REQ-004 SHALL have port in_ready, output, 1, stage can accept an operation this cycle.
REQ-005 SHALL have port alucontrol, input, 3, ALU operation code from the ALU decoder.
REQ-006 SHALL have ports srca and srcb, input, 32 each, operands A and B.
REQ-007 SHALL have ports writereg (input, 5, destination register), regwrite (input, 1, write enable) and branch (input, 1, beq instruction).
REQ-008 SHALL have port flush, input, 1, discard the held operation.
REQ-009 SHALL have port out_valid, output, 1, registered result valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have ports aluresult (output, 32), zero (output, 1, aluresult == 0), out_writereg (output, 5), out_regwrite (output, 1) and branch_taken (output, 1).
REQ-012 SHALL have port overflow, output, 1, signed overflow of the held ADD/SUB.

Function
REQ-013 SHALL compute 000 A&B, 001 A|B, 010 A+B, 011 zero, 100 A&~B, 101 A|~B, 110 A-B, 111 SLT.
REQ-014 SHALL produce SLT as 32'd1 if signed A < signed B, else 32'd0, using the sign of the 33-bit difference corrected for overflow.
REQ-015 SHALL perform ADD/SUB modulo 2^32, discarding carry-out.
REQ-016 SHALL register the result with one-cycle latency: an operation accepted at edge N appears on the outputs after edge N, with out_valid high.
REQ-017 SHALL drive in_ready = !flush && (!out_valid || out_ready), combinationally.
REQ-018 SHALL accept an operation when in_valid && in_ready, capturing aluresult, zero, writereg, regwrite, branch_taken = branch && zero, and overflow.
REQ-019 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid when out_ready is high at an edge and no new operation is accepted.
REQ-021 SHALL support back-to-back throughput of one operation per cycle when out_ready stays high.
REQ-022 SHALL give flush priority: with flush high, out_valid clears at the next edge and any in_valid operation is dropped.
REQ-023 SHALL gate out_regwrite and branch_taken to 0 whenever out_valid is 0.
REQ-024 SHALL treat in_valid low with out_ready high as a drain, so out_valid falls after one edge.

Reset
REQ-025 SHALL, while rst_n is low, force out_valid=0, aluresult=0, zero=0, out_writereg=0, out_regwrite=0, branch_taken=0 and overflow=0 asynchronously.
REQ-026 SHALL drop any held operation on reset asserted mid-transfer, and SHALL accept no operation before the first rising edge after rst_n deasserts.
REQ-027 SHALL drive in_ready=1 from reset, provided flush is low.

Configuration
REQ-028 SHALL compile signed-overflow detection only when macro EX_OVERFLOW_TRAP_EN is defined.
REQ-029 SHALL, with EX_OVERFLOW_TRAP_EN defined, set overflow for ADD/SUB signed overflow and force the captured out_regwrite to 0 for that operation.
REQ-030 SHALL, without EX_OVERFLOW_TRAP_EN, tie overflow to 0 and leave regwrite unmodified.

Verification
REQ-031 SHALL check ADD: srca=32'h7FFFFFFF, srcb=1, alucontrol=010, regwrite=1 -> next cycle aluresult=32'h80000000, zero=0; with the macro, overflow=1 and out_regwrite=0; without it, overflow=0 and out_regwrite=1.
REQ-032 SHALL check SLT: srca=32'hFFFFFFFF, srcb=1, alucontrol=111 -> aluresult=1; swapped operands -> aluresult=0.
REQ-033 SHALL check beq: srca=srcb=32'h1234, alucontrol=110, branch=1 -> aluresult=0, zero=1, branch_taken=1.
REQ-034 SHALL check backpressure: out_ready=0 for 3 cycles after a capture -> outputs unchanged, in_ready=0; out_ready=1 with in_valid=1 -> new operation captured on the same edge.
REQ-035 SHALL check flush: flush=1 with in_valid=1 and out_valid=1 -> in_ready=0, out_valid=0 after the edge, no capture.
REQ-036 SHALL check reset: rst_n pulled low between edges while out_valid=1 -> all outputs 0 immediately, in_ready=1 after release.
